// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver state encoding, frame layout, line polarities
// and default timing used by both the receiver and the host transmitter.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECEIVE = 2'd1,
        CHECK   = 2'd2
    } ps2_state_e;

    localparam int FRAME_LEN = 11;  // start + 8 data + parity + stop
    localparam int DATA_BITS = 8;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic PARITY_ODD = 1'b1;

    localparam int CLK_HZ         = 27_000_000;
    localparam int DEF_FILTER_LEN = 8;
    localparam int DEF_TIMEOUT    = 54_000;  // ~2 ms between bits at CLK_HZ

    // True when data plus parity carries the expected (odd) number of ones.
    function automatic logic parity_ok(input logic [DATA_BITS-1:0] data, input logic par);
        return (^{data, par}) == PARITY_ODD;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a stability filter for one PS/2 line.
// The filtered level only follows the line after FILTER_LEN steady cycles.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_in,
    output logic line_out
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic          sync1_q, sync2_q;
    logic          filt_q, filt_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        if (sync2_q == filt_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
            filt_d = sync2_q;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Idle PS/2 bus floats high, so everything resets to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= line_in;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign line_out = filt_q;

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host receiver: filters both lines, samples data on falling
// clock edges, and reports each 11-bit frame as a byte, parity or framing error.
module ps2_receiver
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = DEF_FILTER_LEN,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    input  logic       rx_enable,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int TW = ($clog2(TIMEOUT) < 1) ? 1 : $clog2(TIMEOUT);

    logic ps2_clk_f, ps2_data_f;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .line_in  (ps2_clk_in),
        .line_out (ps2_clk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .line_in  (ps2_data_in),
        .line_out (ps2_data_f)
    );

    ps2_state_e    state_q, state_d;
    logic          clk_prev_q;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [9:0]    shift_q, shift_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          parity_err_q, parity_err_d;
    logic          frame_err_q, frame_err_d;

    logic       fall;
    logic [9:0] shift_nxt;

    assign fall      = clk_prev_q & ~ps2_clk_f;
    assign shift_nxt = {ps2_data_f, shift_q[9:1]};

    // The frame is judged in the stop-edge cycle so the registered pulses
    // appear during the one-cycle CHECK state, one cycle after that edge.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        tmo_d        = tmo_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;

        if (!rx_enable) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            tmo_d     = '0;
        end else begin
            case (state_q)
                IDLE, CHECK: begin
                    state_d = IDLE;
                    tmo_d   = '0;
                    if (fall && ps2_data_f == START_BIT) begin
                        state_d   = RECEIVE;
                        bit_cnt_d = '0;
                    end
                end
                RECEIVE: begin
                    if (fall) begin
                        shift_d = shift_nxt;
                        tmo_d   = '0;
                        if (bit_cnt_q == 4'(FRAME_LEN - 2)) begin
                            state_d   = CHECK;
                            bit_cnt_d = '0;
                            if (shift_nxt[9] != STOP_BIT) begin
                                frame_err_d = 1'b1;
                            end else if (!parity_ok(shift_nxt[7:0], shift_nxt[8])) begin
                                parity_err_d = 1'b1;
                            end else begin
                                rx_data_d  = shift_nxt[7:0];
                                rx_valid_d = 1'b1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                        frame_err_d = 1'b1;
                        state_d     = IDLE;
                        bit_cnt_d   = '0;
                        tmo_d       = '0;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
                default: begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    tmo_d     = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            clk_prev_q   <= 1'b1;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            tmo_q        <= '0;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            clk_prev_q   <= ps2_clk_f;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            tmo_q        <= tmo_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_receiver.sv
// Self-checking bench for ps2_receiver: table of frames plus hand-built corner
// sequences, with a scoreboard of expected result pulses.
module tb_ps2_receiver;

    localparam int FL = 8;
    localparam int TO = 300;
    localparam int QP = 20;  // quarter of a PS/2 bit period, in clk cycles

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk_in = 1'b1;
    logic       ps2_data_in = 1'b1;
    logic       rx_enable = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, parity_err, frame_err, busy;

    ps2_receiver #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .rx_enable   (rx_enable),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {K_VALID, K_PERR, K_FERR} kind_e;
    typedef struct {
        kind_e      kind;
        logic [7:0] data;
        int         lo;
        int         hi;
    } exp_t;
    typedef struct {
        logic [7:0] b;
        bit         bad_par;
        bit         stop;
        kind_e      kind;
        logic [7:0] exp_data;
    } vec_t;

    exp_t       sbq[$];
    int         tests = 0;
    int         fails = 0;
    int         last_fall_cyc = 0;
    logic [7:0] prev_rx = 8'h00;
    bit         chk_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par, input bit stop);
        logic p;
        p = ~(^b) ^ bad_par;
        return {stop, p, b, 1'b0};
    endfunction

    task automatic drive_bit(input logic b);
        ps2_data_in = b;
        repeat (QP) @(negedge clk);
        ps2_clk_in = 1'b0;
        last_fall_cyc = cyc;
        repeat (2 * QP) @(negedge clk);
        ps2_clk_in = 1'b1;
        repeat (QP) @(negedge clk);
    endtask

    task automatic send_bits(input logic [10:0] bits, input int first, input int last);
        for (int i = first; i <= last; i++) drive_bit(bits[i]);
        ps2_data_in = 1'b1;
    endtask

    task automatic drain(input string name, input int budget);
        int k;
        k = 0;
        while (sbq.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, sbq.size(), 0);
    endtask

    task automatic push(input kind_e k, input logic [7:0] d, input int lo, input int hi);
        exp_t e;
        e.kind = k; e.data = d; e.lo = lo; e.hi = hi;
        sbq.push_back(e);
    endtask

    // Monitor: every result pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t  e;
        kind_e k;
        int    lat;
        if (!rst_n) begin
            prev_rx  = rx_data;
            chk_busy = 1'b0;
        end else begin
            if (chk_busy) begin
                chk_busy = 1'b0;
                tests++;
                if (busy !== 1'b0) begin
                    fails++;
                    $display("FAIL busy_after_pulse: got %0b expected 0", busy);
                end
            end
            if (rx_valid || parity_err || frame_err) begin
                tests++;
                k   = rx_valid ? K_VALID : (parity_err ? K_PERR : K_FERR);
                lat = cyc - last_fall_cyc;
                if ((rx_valid + parity_err + frame_err) > 1) begin
                    fails++;
                    $display("FAIL one_hot: valid=%0b perr=%0b ferr=%0b expected at most one",
                             rx_valid, parity_err, frame_err);
                end else if (sbq.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_pulse: got kind %0d expected none", k);
                end else begin
                    e = sbq.pop_front();
                    if (k != e.kind || rx_data !== e.data || lat < e.lo || lat > e.hi) begin
                        fails++;
                        $display("FAIL pulse: got kind %0d data %0h lat %0d expected kind %0d data %0h lat %0d..%0d",
                                 k, rx_data, lat, e.kind, e.data, e.lo, e.hi);
                    end
                end
                chk_busy = 1'b1;
            end
            if (rx_data !== prev_rx && !rx_valid) begin
                fails++;
                $display("FAIL rx_data_change: got %0h without rx_valid, expected %0h", rx_data, prev_rx);
            end
            prev_rx = rx_data;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vec_t       vt[9];
        logic [10:0] bits;

        vt[0] = '{8'hFA, 1'b0, 1'b1, K_VALID, 8'hFA};
        vt[1] = '{8'h08, 1'b1, 1'b1, K_PERR,  8'hFA};
        vt[2] = '{8'h55, 1'b0, 1'b0, K_FERR,  8'hFA};
        vt[3] = '{8'h00, 1'b0, 1'b1, K_VALID, 8'h00};
        vt[4] = '{8'hFF, 1'b0, 1'b1, K_VALID, 8'hFF};
        vt[5] = '{8'h01, 1'b1, 1'b1, K_PERR,  8'hFF};
        vt[6] = '{8'h80, 1'b0, 1'b1, K_VALID, 8'h80};
        vt[7] = '{8'h3C, 1'b0, 1'b0, K_FERR,  8'h80};
        vt[8] = '{8'hC3, 1'b0, 1'b1, K_VALID, 8'hC3};

        // Reset state
        repeat (5) @(negedge clk);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_parity_err", parity_err, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // Table of whole frames
        for (int i = 0; i < 9; i++) begin
            push(vt[i].kind, vt[i].exp_data, 4, 20);
            send_bits(mk_frame(vt[i].b, vt[i].bad_par, vt[i].stop), 0, 10);
            drain($sformatf("frame_%0d", i), 100);
            check($sformatf("frame_%0d_data", i), rx_data, vt[i].exp_data);
        end

        // Clock stops after start + 4 data bits: inter-bit timeout
        push(K_FERR, 8'hC3, TO, TO + 25);
        send_bits(mk_frame(8'h9A, 1'b0, 1'b1), 0, 4);
        drain("timeout", TO + 100);
        check("timeout_busy", busy, 1'b0);

        push(K_VALID, 8'hAA, 4, 20);
        send_bits(mk_frame(8'hAA, 1'b0, 1'b1), 0, 10);
        drain("after_timeout", 100);

        // rx_enable dropped mid-frame: frame discarded silently
        bits = mk_frame(8'h33, 1'b0, 1'b1);
        send_bits(bits, 0, 4);
        check("en_busy_mid", busy, 1'b1);
        rx_enable = 1'b0;
        @(negedge clk);
        check("en_busy_drop", busy, 1'b0);
        send_bits(bits, 5, 10);
        repeat (50) @(negedge clk);
        rx_enable = 1'b1;
        repeat (50) @(negedge clk);
        check("en_no_pulse", sbq.size(), 0);
        check("en_rx_data", rx_data, 8'hAA);

        // 3-cycle clock glitch mid-frame must not shift a bit
        bits = mk_frame(8'h5A, 1'b0, 1'b1);
        push(K_VALID, 8'h5A, 4, 20);
        send_bits(bits, 0, 4);
        ps2_clk_in = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk_in = 1'b1;
        repeat (20) @(negedge clk);
        send_bits(bits, 5, 10);
        drain("glitch", 100);

        // Reset mid-frame, then a fresh frame
        send_bits(mk_frame(8'h0F, 1'b0, 1'b1), 0, 3);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_rx_data", rx_data, 8'h00);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_pulses", {rx_valid, parity_err, frame_err}, 3'b000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("post_rst_busy", busy, 1'b0);
        push(K_VALID, 8'hF4, 4, 20);
        send_bits(mk_frame(8'hF4, 1'b0, 1'b1), 0, 10);
        drain("after_reset", 100);
        check("after_reset_data", rx_data, 8'hF4);

        repeat (20) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ps2_receiver.md
PS2_RECEIVER -- requirements
Module: ps2_receiver

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8, meaning the number of consecutive clk cycles a synchronized PS/2 line must hold a new level before the filtered level changes.
REQ-002 SHALL have parameter TIMEOUT, default 54000, meaning the clk cycles allowed between consecutive frame bits (about 2 ms at 27 MHz).
REQ-003 SHALL have port clk  input  1  system clock (27 MHz nominal).
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ps2_clk_in  input  1  raw PS/2 clock line (device-driven).
REQ-006 SHALL have port ps2_data_in  input  1  raw PS/2 data line.
REQ-007 SHALL have port rx_enable  input  1  high = receive allowed; driven low by the host transmitter while it owns the bus.
REQ-008 SHALL have port rx_data  output  8  last correctly received byte.
REQ-009 SHALL have port rx_valid  output  1  one-cycle pulse, rx_data updated.
REQ-010 SHALL have port parity_err  output  1  one-cycle pulse, parity mismatch.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse, bad stop bit or inter-bit timeout.
REQ-012 SHALL have port busy  output  1  high while a frame is in progress.

Function
REQ-013 SHALL pass both PS/2 lines through a two-flop synchronizer, then a FILTER_LEN stability filter; all decoding SHALL use the filtered levels only.
REQ-014 SHALL detect a falling edge when the filtered clock goes 1->0; data SHALL be sampled from filtered data in the same cycle the edge is detected.
REQ-015 SHALL implement states IDLE, RECEIVE, CHECK.
REQ-016 IDLE: on a falling edge with data=0 (start bit) and rx_enable=1 -> RECEIVE, busy=1, bit counter=0; on a falling edge with data=1 -> stay in IDLE, no error.
REQ-017 RECEIVE: each falling edge shifts in one bit, LSB first: 8 data bits, then parity, then stop; after the stop-bit edge -> CHECK.
REQ-018 CHECK (one cycle): if stop=0 -> frame_err; else if data plus parity has an even count of ones -> parity_err; else rx_data <= byte and rx_valid; then -> IDLE, busy=0.
REQ-019 Latency: rx_valid, parity_err or frame_err SHALL assert exactly 1 cycle after the cycle in which the stop-bit edge is detected.
REQ-020 At most one of rx_valid, parity_err, frame_err SHALL be high in any cycle; rx_data SHALL change only together with rx_valid.
REQ-021 Timeout: in RECEIVE, a counter SHALL reload on each falling edge; if TIMEOUT cycles pass with no edge -> frame_err pulse, -> IDLE, busy=0.
REQ-022 rx_enable=0 in any state SHALL force IDLE on the next cycle, clear the bit counter, set busy=0 and produce no pulses; a partial frame SHALL be discarded.
REQ-023 A falling edge that coincides with a timeout expiry SHALL take priority: the bit is accepted and the counter reloads.
REQ-024 Back-to-back frames: a start bit arriving on the first edge after CHECK SHALL be accepted.

Reset
REQ-025 On rst_n low: state=IDLE, rx_data=8'h00, rx_valid=0, parity_err=0, frame_err=0, busy=0, counters=0, synchronizer and filter outputs=1 (idle bus).
REQ-026 Reset asserted mid-frame SHALL discard the frame; after release, reception SHALL restart only on a new start bit.

Structure
REQ-027 Shared package ps2_pkg SHALL hold the state encoding, the frame length (11), the start, stop and parity polarity constants, and default timing constants shared with the transmitter.
REQ-028 The synchronizer plus stability filter SHALL be a sub-module ps2_line_filter, instantiated once per line.

Verification
REQ-029 Frame 0xFA, parity=1, stop=1, bit period 80 us -> one rx_valid, rx_data=0xFA, no error pulses.
REQ-030 Frame 0x08 with parity=1 (wrong) -> one parity_err pulse, no rx_valid, rx_data unchanged.
REQ-031 Frame 0x55 with stop=0 -> one frame_err pulse, busy low on the next cycle.
REQ-032 Stop the PS/2 clock after 4 bits -> frame_err TIMEOUT cycles after the last edge; a following 0xAA frame is received correctly.
REQ-033 Drop rx_enable low mid-frame -> busy=0 next cycle, no pulses; a 3-cycle glitch on ps2_clk_in (FILTER_LEN=8) -> no bit shifted.
REQ-034 Assert rst_n mid-frame, then send 0xF4 -> all outputs at reset values, then rx_data=0xF4 with one rx_valid.
